// File: rtl/regfile_sequencer_if.sv
// Command/response channel bundle for regfile_sequencer.
// Both channels use valid/ready handshaking: a transfer happens on a rising
// edge where valid and ready are both high; the sender keeps valid and its
// payload stable until that edge, and valid never depends on ready.
interface regfile_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [ADDR_WIDTH-1:0] cmd_rs1;
    logic [ADDR_WIDTH-1:0] cmd_rs2;
    logic [DATA_WIDTH-1:0] cmd_imm;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data1;
    logic [DATA_WIDTH-1:0] rsp_data2;
    logic                  rsp_carry;

    // Issuer of commands / consumer of responses.
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_carry
    );

    // The sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_carry
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: drives the register file read/write port for one command
// at a time (IDLE -> EXEC -> RESP). Ops: WRITE imm, READ rs1/rs2, MOVE rs1->rd,
// ADD rs1+rs2->rd with carry-out.
// Optional feature: define REGSEQ_ZERO_REG_EN to make register 0 read as zero
// and ignore writes to it (the response is still produced).
module regfile_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_sequencer_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] rf_read_reg1,
    output logic [ADDR_WIDTH-1:0] rf_read_reg2,
    output logic [ADDR_WIDTH-1:0] rf_write_reg,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_reg_write,
    input  logic [DATA_WIDTH-1:0] rf_read_data1,
    input  logic [DATA_WIDTH-1:0] rf_read_data2,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_WIDTH-1:0] rsp_data2_q, rsp_data2_d;
    logic                  rsp_carry_q, rsp_carry_d;

    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic                  rd_is_zero;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] result;
    logic                  write_en;

`ifdef REGSEQ_ZERO_REG_EN
    assign src1       = (rs1_q == '0) ? '0 : rf_read_data1;
    assign src2       = (rs2_q == '0) ? '0 : rf_read_data2;
    assign rd_is_zero = (rd_q == '0);
`else
    assign src1       = rf_read_data1;
    assign src2       = rf_read_data2;
    assign rd_is_zero = 1'b0;
`endif

    // Operation datapath: what EXEC would write back and report.
    always_comb begin
        sum      = {1'b0, src1} + {1'b0, src2};
        result   = src1;
        write_en = 1'b0;
        case (op_q)
            OP_WRITE: begin result = imm_q;                     write_en = 1'b1; end
            OP_READ:  begin result = src1;                      write_en = 1'b0; end
            OP_MOVE:  begin result = src1;                      write_en = 1'b1; end
            default:  begin result = sum[DATA_WIDTH-1:0];       write_en = 1'b1; end
        endcase
        if (rd_is_zero) begin
            write_en = 1'b0;
        end
    end

    // Next-state, command capture, register-file port and response loading.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        rsp_data1_d   = rsp_data1_q;
        rsp_data2_d   = rsp_data2_q;
        rsp_carry_d   = rsp_carry_q;
        rf_read_reg1  = '0;
        rf_read_reg2  = '0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_reg_write  = 1'b0;
        bus.cmd_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = ~reset;
                if (bus.cmd_valid && !reset) begin
                    op_d    = bus.cmd_op;
                    rd_d    = bus.cmd_rd;
                    rs1_d   = bus.cmd_rs1;
                    rs2_d   = bus.cmd_rs2;
                    imm_d   = bus.cmd_imm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_read_reg1  = rs1_q;
                rf_read_reg2  = rs2_q;
                rf_write_reg  = rd_q;
                rf_write_data = result;
                // A reset during EXEC must suppress the register-file write.
                rf_reg_write  = write_en & ~reset;
                rsp_data1_d   = result;
                rsp_data2_d   = (op_q == OP_READ) ? src2 : '0;
                rsp_carry_d   = (op_q == OP_ADD) ? sum[DATA_WIDTH] : 1'b0;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; command fields only change when captured.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        rd_q  <= rd_d;
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        imm_q <= imm_d;
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_data2 = rsp_data2_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign dbg_state     = state_q;
endmodule
